// File: rtl/circle_scan.sv
// Sequential driver for the point-in-circle judge: sweeps an 8x8 grid one point per cycle,
// presents registered squared distances to the combinational judge and counts hits.
module circle_scan #(
  parameter int unsigned COORD_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] r,
  input  logic               ans,
  output logic [7:0]         square_x,
  output logic [7:0]         square_y,
  output logic [7:0]         square_r,
  output logic               busy,
  output logic               done,
  output logic [6:0]         count
);

  localparam int unsigned IdxW = 2 * COORD_W;

  typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [COORD_W-1:0]  cx_q, cx_d;
  logic [COORD_W-1:0]  cy_q, cy_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [7:0]          square_x_q, square_x_d;
  logic [7:0]          square_y_q, square_y_d;
  logic [7:0]          square_r_q, square_r_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [6:0]          count_q, count_d;

  // (p - c)^2 via magnitude of a one-bit-wider signed difference.
  function automatic logic [7:0] sq_diff(input logic [COORD_W-1:0] p,
                                         input logic [COORD_W-1:0] c);
    logic [COORD_W:0]   d;
    logic [COORD_W:0]   d_neg;
    logic [COORD_W-1:0] mag;
    logic [7:0]         w;
    d     = {1'b0, p} - {1'b0, c};
    d_neg = -d;
    mag   = d[COORD_W] ? d_neg[COORD_W-1:0] : d[COORD_W-1:0];
    w     = {{(8-COORD_W){1'b0}}, mag};
    return w * w;
  endfunction

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    square_x_d = square_x_q;
    square_y_d = square_y_q;
    square_r_d = square_r_q;
    busy_d     = busy_q;
    done_d     = done_q;
    count_d    = count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cx_d       = cx;
          cy_d       = cy;
          square_r_d = sq_diff(r, '0);
          count_d    = '0;
          idx_d      = '0;
          valid_d    = 1'b0;
          busy_d     = 1'b1;
          state_d    = StScan;
        end
      end
      StScan: begin
        square_x_d = sq_diff(idx_q[COORD_W-1:0], cx_q);
        square_y_d = sq_diff(idx_q[IdxW-1:COORD_W], cy_q);
        valid_d    = 1'b1;
        idx_d      = idx_q + IdxW'(1);
        // ans belongs to the point issued on the previous edge
        if (valid_q) count_d = count_q + {6'b0, ans};
        if (idx_q == '1) state_d = StDrain;
      end
      StDrain: begin
        count_d = count_q + {6'b0, ans};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = StDone;
      end
      StDone: begin
        done_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cx_q       <= '0;
      cy_q       <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      square_x_q <= '0;
      square_y_q <= '0;
      square_r_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      square_x_q <= square_x_d;
      square_y_q <= square_y_d;
      square_r_q <= square_r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      count_q    <= count_d;
    end
  end

  assign square_x = square_x_q;
  assign square_y = square_y_q;
  assign square_r = square_r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign count    = count_q;

endmodule

// File: tb/tb_circle_scan.sv
// Bench for circle_scan: behavioural judge on the square_* outputs, expected counts queued at
// start and compared when done pulses.
module tb_circle_scan;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] cx, cy, r;
  logic       ans;
  logic [7:0] square_x, square_y, square_r;
  logic       busy, done;
  logic [6:0] count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int exp_q[$];

  circle_scan #(.COORD_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cx       (cx),
    .cy       (cy),
    .r        (r),
    .ans      (ans),
    .square_x (square_x),
    .square_y (square_y),
    .square_r (square_r),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Judge: inside or on the circle when r^2 - dx^2 - dy^2 >= 0.
  assign ans = (int'(square_r) >= int'(square_x) + int'(square_y));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_scan(input int x, input int y, input int rr, input int exp_count);
    @(negedge clk);
    cx    = 3'(x);
    cy    = 3'(y);
    r     = 3'(rr);
    start = 1'b1;
    exp_q.push_back(exp_count);
    @(negedge clk);
    start = 1'b0;
    t0    = cyc;
    check_eq("busy_after_start", 32'(busy), 1);
    check_eq("square_r", 32'(square_r), 32'(rr * rr));
    @(negedge clk);
    check_eq("square_x_p0", 32'(square_x), 32'(x * x));
    check_eq("square_y_p0", 32'(square_y), 32'(y * y));
  endtask

  task automatic wait_done();
    int n        = 0;
    int busy_err = 0;
    int exp_c    = -1;
    while (!done && n < 200) begin
      if (!busy) busy_err++;
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done), 1);
    check_eq("latency", 32'(cyc - t0), 65);
    check_eq("busy_held", 32'(busy_err), 0);
    check_eq("busy_low_at_done", 32'(busy), 0);
    check_eq("sb_nonempty", 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) exp_c = exp_q.pop_front();
    check_eq("count", 32'(count), 32'(exp_c));
    @(negedge clk);
    check_eq("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    logic [6:0] held;
    reset = 1'b1;
    start = 1'b0;
    cx    = '0;
    cy    = '0;
    r     = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_sqx", 32'(square_x), 0);
    check_eq("rst_sqy", 32'(square_y), 0);
    check_eq("rst_sqr", 32'(square_r), 0);
    reset = 1'b0;

    start_scan(3, 3, 0, 1);
    wait_done();
    start_scan(3, 3, 2, 13);
    wait_done();
    start_scan(0, 0, 7, 45);
    wait_done();
    start_scan(7, 7, 7, 45);
    wait_done();

    // Start pulsed mid-scan with different circle must be ignored.
    start_scan(3, 3, 1, 5);
    repeat (20) @(negedge clk);
    cx    = 3'd0;
    cy    = 3'd0;
    r     = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start_scan(3, 3, 2, 13);
    wait_done();

    // Count must hold while idle.
    held = count;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("idle_hold_count", 32'(count), 32'(held));
    end
    check_eq("idle_hold_value", 32'(held), 13);

    // Abort mid-scan via reset.
    start_scan(3, 3, 0, 1);
    repeat (28) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_count", 32'(count), 0);
    check_eq("abort_sqx", 32'(square_x), 0);
    check_eq("abort_sqy", 32'(square_y), 0);
    check_eq("abort_sqr", 32'(square_r), 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_eq("abort_no_done", 32'(done), 0);

    start_scan(3, 3, 0, 1);
    wait_done();

    check_eq("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
